chunk_coord_generator: RTL

- Upstream stage of coordinate_wrapper: walks a square chunk of the universe and emits one signed (x, y) coordinate pair per cycle with a ce strobe.
- Output x and y each feed one coordinate_wrapper instance, whose outputs feed the MiMC hash pipeline.
- Scan order is row-major: x is the inner loop and y is the outer loop.

---
 rtl/df_miner_pkg.sv | 12 +
 rtl/chunk_coord_generator_if.sv | 29 ++
 rtl/chunk_coord_generator_counter.sv | 25 ++
 rtl/chunk_coord_generator.sv | 82 ++++++++
 4 files changed

// File: rtl/df_miner_pkg.sv
// Shared definitions for the df_miner datapath: generator FSM encoding and
// the coordinate width common to coordinate_wrapper and the MiMC stages.
package df_miner_pkg;
  localparam int COORD_W = 256;
  localparam int SIZE_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } gen_state_e;
endpackage

// File: rtl/chunk_coord_generator_if.sv
// Host <-> chunk_coord_generator bundle. pause exists only when GEN_PAUSE_EN
// is defined.
interface chunk_coord_generator_if import df_miner_pkg::*; #(
  parameter int SIZE_WIDTH  = SIZE_W,
  parameter int COORD_WIDTH = COORD_W
) ();
  logic                   start;
  logic [COORD_WIDTH-1:0] origin_x;
  logic [COORD_WIDTH-1:0] origin_y;
  logic [SIZE_WIDTH-1:0]  chunk_size;
  logic                   busy;
  logic                   done;
  logic                   ce_out;
  logic [COORD_WIDTH-1:0] coord_x;
  logic [COORD_WIDTH-1:0] coord_y;
`ifdef GEN_PAUSE_EN
  logic                   pause;

  modport master (output start, origin_x, origin_y, chunk_size, pause,
                  input  busy, done, ce_out, coord_x, coord_y);
  modport slave  (input  start, origin_x, origin_y, chunk_size, pause,
                  output busy, done, ce_out, coord_x, coord_y);
`else
  modport master (output start, origin_x, origin_y, chunk_size,
                  input  busy, done, ce_out, coord_x, coord_y);
  modport slave  (input  start, origin_x, origin_y, chunk_size,
                  output busy, done, ce_out, coord_x, coord_y);
`endif
endinterface

// File: rtl/chunk_coord_generator_counter.sv
// chunk_axis_counter: one scan axis, counts 0..limit-1 and flags the last value.
module chunk_axis_counter #(
  parameter int SIZE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  input  logic [SIZE_WIDTH-1:0] limit,
  output logic [SIZE_WIDTH-1:0] value,
  output logic                  wrap
);
  localparam logic [SIZE_WIDTH-1:0] ONE = SIZE_WIDTH'(1);

  logic [SIZE_WIDTH-1:0] r_value;

  assign value = r_value;
  assign wrap  = (r_value == (limit - ONE));

  always_ff @(posedge clk) begin
    if (rst)          r_value <= '0;
    else if (clear)   r_value <= '0;
    else if (advance) r_value <= wrap ? '0 : r_value + ONE;
  end
endmodule

// File: rtl/chunk_coord_generator.sv
// Row-major chunk scanner feeding coordinate_wrapper: one (x, y) per ce_out.
// Optional host throttling via the pause input when GEN_PAUSE_EN is defined.
module chunk_coord_generator import df_miner_pkg::*; #(
  parameter int SIZE_WIDTH  = SIZE_W,
  parameter int COORD_WIDTH = COORD_W
) (
  input logic                    clk,
  input logic                    rst,
  chunk_coord_generator_if.slave bus
);
  gen_state_e             r_state, w_next;
  logic [COORD_WIDTH-1:0] r_origin_x, r_origin_y;
  logic [SIZE_WIDTH-1:0]  r_size;
  logic [COORD_WIDTH-1:0] r_coord_x, r_coord_y;
  logic                   r_ce, r_done;

  logic                   w_accept, w_emit, w_last;
  logic                   w_x_wrap, w_y_wrap;
  logic [SIZE_WIDTH-1:0]  w_x_val, w_y_val;

  // r_done blocks a start that arrives while the done pulse is visible.
  assign w_accept = (r_state == ST_IDLE) && bus.start && !r_done;
`ifdef GEN_PAUSE_EN
  assign w_emit   = (r_state == ST_RUN) && !bus.pause;
`else
  assign w_emit   = (r_state == ST_RUN);
`endif
  assign w_last   = w_emit && w_x_wrap && w_y_wrap;

  chunk_axis_counter #(.SIZE_WIDTH(SIZE_WIDTH)) u_x_cnt (
    .clk(clk), .rst(rst), .clear(w_accept), .advance(w_emit),
    .limit(r_size), .value(w_x_val), .wrap(w_x_wrap)
  );

  chunk_axis_counter #(.SIZE_WIDTH(SIZE_WIDTH)) u_y_cnt (
    .clk(clk), .rst(rst), .clear(w_accept), .advance(w_emit && w_x_wrap),
    .limit(r_size), .value(w_y_val), .wrap(w_y_wrap)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = (bus.chunk_size == '0) ? ST_FIN : ST_RUN;
      ST_RUN:  if (w_last)   w_next = ST_FIN;
      ST_FIN:                w_next = ST_IDLE;
      default:               w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_origin_x <= '0;
      r_origin_y <= '0;
      r_size     <= '0;
      r_coord_x  <= '0;
      r_coord_y  <= '0;
      r_ce       <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ce    <= w_emit;
      r_done  <= (r_state == ST_FIN);
      if (w_accept) begin
        r_origin_x <= bus.origin_x;
        r_origin_y <= bus.origin_y;
        r_size     <= bus.chunk_size;
      end
      // Zero-extended offsets; the add wraps modulo 2^COORD_WIDTH by design.
      if (w_emit) begin
        r_coord_x <= r_origin_x + {{(COORD_WIDTH-SIZE_WIDTH){1'b0}}, w_x_val};
        r_coord_y <= r_origin_y + {{(COORD_WIDTH-SIZE_WIDTH){1'b0}}, w_y_val};
      end
    end
  end

  assign bus.busy    = (r_state != ST_IDLE);
  assign bus.done    = r_done;
  assign bus.ce_out  = r_ce;
  assign bus.coord_x = r_coord_x;
  assign bus.coord_y = r_coord_y;
endmodule
